// File: rtl/demux2buf.sv
// Two-way demultiplexer feeding a pair of single-entry output buffers.
// Each channel keeps its own valid flag and a delivered-word counter.
module demux2buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [WIDTH-1:0] y1,
  output logic             y1_valid,
  input  logic             y1_ready,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
);

  logic acc0, acc1;
  logic xfer0, xfer1;

  // Only the selected channel's buffer state decides whether the word can be taken.
  always_comb begin
    in_ready = s ? (!y1_valid || y1_ready) : (!y0_valid || y0_ready);
  end

  assign acc0  = in_valid && in_ready && !s;
  assign acc1  = in_valid && in_ready && s;
  assign xfer0 = y0_valid && y0_ready;
  assign xfer1 = y1_valid && y1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      y0       <= '0;
      y1       <= '0;
      y0_valid <= 1'b0;
      y1_valid <= 1'b0;
      cnt0     <= 8'd0;
      cnt1     <= 8'd0;
    end else begin
      if (acc0) y0 <= d;
      if (acc1) y1 <= d;
      // A same-edge accept refills the slot being drained, so valid stays high.
      y0_valid <= acc0 || (y0_valid && !y0_ready);
      y1_valid <= acc1 || (y1_valid && !y1_ready);
      if (xfer0) cnt0 <= cnt0 + 8'd1;
      if (xfer1) cnt1 <= cnt1 + 8'd1;
    end
  end

endmodule

// File: tb/tb_demux2buf.sv
// Randomized bench for demux2buf: directed scenarios followed by random traffic,
// all checked against a per-channel buffer model held in small arrays.
module tb_demux2buf;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] d;
  logic             s;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y0;
  logic             y0_valid;
  logic             y0_ready;
  logic [WIDTH-1:0] y1;
  logic             y1_valid;
  logic             y1_ready;
  logic [7:0]       cnt0;
  logic [7:0]       cnt1;

  demux2buf #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .d(d), .s(s), .in_valid(in_valid), .in_ready(in_ready),
    .y0(y0), .y0_valid(y0_valid), .y0_ready(y0_ready),
    .y1(y1), .y1_valid(y1_valid), .y1_ready(y1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // reference state: one buffered word per channel plus delivery counts
  logic [WIDTH-1:0] md[2];
  logic             mv[2];
  int               mc[2];
  bit               model_ok = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: drive at negedge, check in_ready, model the edge, check outputs
  task automatic cycle(input logic r, input logic [WIDTH-1:0] dd, input logic ss,
                       input logic iv, input logic r0, input logic r1);
    logic rr[2];
    rr[0] = r0;
    rr[1] = r1;
    rst = r; d = dd; s = ss; in_valid = iv; y0_ready = r0; y1_ready = r1;
    #1;
    if (model_ok) check("in_ready", in_ready, 32'(!mv[ss] || rr[ss]));
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        mv[i] = 1'b0; md[i] = '0; mc[i] = 0;
      end
      model_ok = 1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit xf, ac;
        xf = mv[i] && rr[i];
        ac = iv && (int'(ss) == i) && (!mv[i] || rr[i]);
        if (xf) mc[i] = (mc[i] + 1) % 256;
        if (ac) begin
          md[i] = dd;
          mv[i] = 1'b1;
        end else if (xf) begin
          mv[i] = 1'b0;
        end
      end
    end
    @(negedge clk);
    if (model_ok) begin
      check("y0", y0, md[0]);
      check("y1", y1, md[1]);
      check("y0_valid", y0_valid, mv[0]);
      check("y1_valid", y1_valid, mv[1]);
      check("cnt0", cnt0, mc[0]);
      check("cnt1", cnt1, mc[1]);
    end
  endtask

  initial begin
    rst = 1'b1; d = '0; s = 1'b0; in_valid = 1'b0; y0_ready = 1'b0; y1_ready = 1'b0;
    @(negedge clk);

    // reset: two cycles with live traffic that must be ignored
    cycle(1, 4'hF, 0, 1, 1, 1);
    cycle(1, 4'hF, 1, 1, 1, 1);
    check("rst_y0", y0, 0);
    check("rst_y1", y1, 0);
    check("rst_v0", y0_valid, 0);
    check("rst_v1", y1_valid, 0);
    check("rst_cnt0", cnt0, 0);
    check("rst_cnt1", cnt1, 0);
    rst = 1'b0; in_valid = 1'b0; y0_ready = 1'b0; y1_ready = 1'b0;
    s = 1'b0; #1 check("rst_rdy_s0", in_ready, 1);
    s = 1'b1; #1 check("rst_rdy_s1", in_ready, 1);

    // basic routing
    cycle(0, 4'b1010, 0, 1, 0, 0);
    check("route_y0", y0, 4'b1010);
    check("route_v0", y0_valid, 1);
    check("route_v1", y1_valid, 0);
    cycle(0, 4'b0101, 1, 1, 0, 0);
    check("route_y1", y1, 4'b0101);
    check("route_y0_hold", y0, 4'b1010);

    // backpressure: drain y1, keep y0 stalled, then try both channels
    cycle(0, 4'h0, 0, 0, 0, 1);
    cycle(0, 4'h7, 0, 1, 0, 0);
    check("bp_y0_hold", y0, 4'b1010);
    check("bp_v0", y0_valid, 1);
    cycle(0, 4'h9, 1, 1, 0, 0);
    check("bp_y1_acc", y1, 4'h9);
    check("bp_v1", y1_valid, 1);

    // streaming back-to-back on channel 0 from a clean start
    cycle(1, 4'h0, 0, 0, 0, 0);
    cycle(0, 4'b1100, 0, 1, 1, 0);
    check("strm_y0_a", y0, 4'b1100);
    check("strm_v0_a", y0_valid, 1);
    cycle(0, 4'b0011, 0, 1, 1, 0);
    check("strm_y0_b", y0, 4'b0011);
    check("strm_v0_b", y0_valid, 1);
    cycle(0, 4'h0, 0, 0, 1, 0);
    check("strm_cnt0", cnt0, 2);
    check("strm_v0_c", y0_valid, 0);
    check("strm_y0_keep", y0, 4'b0011);

    // 256 deliveries on channel 1
    cycle(0, 4'h1, 1, 1, 0, 0);
    for (int i = 0; i < 255; i++) cycle(0, 4'($urandom), 1, 1, 0, 1);
    cycle(0, 4'h0, 1, 0, 0, 1);
    check("wrap_cnt1", cnt1, 0);
    check("wrap_cnt0", cnt0, 2);
    check("wrap_v1", y1_valid, 0);

    // reset with both channels full; old words must never show up
    cycle(0, 4'hA, 0, 1, 0, 0);
    cycle(0, 4'hB, 1, 1, 0, 0);
    cycle(1, 4'h0, 0, 0, 1, 1);
    check("mrst_v0", y0_valid, 0);
    check("mrst_v1", y1_valid, 0);
    check("mrst_cnt0", cnt0, 0);
    check("mrst_cnt1", cnt1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 4'h0, 0, 0, 1, 1);
    check("mrst_cnt0_after", cnt0, 0);
    check("mrst_cnt1_after", cnt1, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0), 4'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/demux2buf.md
DEMUX2BUF -- requirements
Module: demux2buf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data width of the input and both output channels.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port d, input, WIDTH bits, the input data word.
REQ-005 The block SHALL have port s, input, 1 bit, the channel select: 0 routes to channel 0, 1 routes to channel 1.
REQ-006 The block SHALL have port in_valid, input, 1 bit, asserted when d/s carry a word.
REQ-007 The block SHALL have port in_ready, output, 1 bit, asserted when the block can accept a word for the currently selected channel.
REQ-008 The block SHALL have port y0, output, WIDTH bits, the channel 0 holding register.
REQ-009 The block SHALL have port y0_valid, output, 1 bit, asserted when y0 holds an undelivered word.
REQ-010 The block SHALL have port y0_ready, input, 1 bit, the channel 0 consumer accept.
REQ-011 The block SHALL have ports y1, y1_valid and y1_ready, with the same widths and directions as y0, y0_valid and y0_ready, for channel 1.
REQ-012 The block SHALL have ports cnt0 and cnt1, outputs, 8 bits each, counting words delivered on channel 0 and channel 1.

Function
REQ-013 Each channel SHALL be a single-entry buffer consisting of a data register and a valid flag.
REQ-014 in_ready SHALL be combinational: in_ready = !yS_valid | yS_ready, where S = s; the other channel's state SHALL NOT affect it.
REQ-015 An input accept SHALL occur on a clock edge where in_valid and in_ready are both 1; s SHALL be ignored when in_valid = 0.
REQ-016 On an input accept, d SHALL load into y[s] and y[s]_valid SHALL be 1 from the next cycle, giving a latency of 1 cycle.
REQ-017 An output transfer on channel i SHALL occur on an edge where yi_valid and yi_ready are both 1.
REQ-018 After an output transfer with no accept to the same channel on that edge, yi_valid SHALL clear on the next cycle.
REQ-019 When an output transfer on channel i and an input accept to channel i occur on the same edge, yi_valid SHALL stay 1 and yi SHALL take the new d, with no bubble and no loss.
REQ-020 While yi_valid = 1 and yi_ready = 0, yi SHALL hold stable and no input accept to channel i SHALL occur.
REQ-021 The two channels SHALL drain independently; simultaneous output transfers on both channels SHALL be legal.
REQ-022 A full channel SHALL NOT block input to the other channel.
REQ-023 cntI SHALL increment by 1 on each output transfer of channel I and SHALL wrap from 255 to 0.
REQ-024 yi_ready asserted while yi_valid = 0 SHALL have no effect on any state, including cntI.
REQ-025 yi SHALL retain its last value after delivery until it is overwritten by the next accept.

Reset
REQ-026 While rst = 1 at a clock edge, y0, y1, cnt0 and cnt1 SHALL become 0, and y0_valid and y1_valid SHALL become 0.
REQ-027 Reset SHALL take priority over a simultaneous accept or transfer, and any buffered undelivered word SHALL be discarded.
REQ-028 In the first cycle after reset, in_ready SHALL be 1 for either value of s.

Verification
REQ-029 Reset check: rst = 1 for 2 cycles -> all outputs are 0 and in_ready = 1.
REQ-030 Basic routing: d = 1010, s = 0, in_valid pulse with y0_ready = 0 -> next cycle y0 = 1010 and y0_valid = 1, y1_valid = 0; then d = 0101, s = 1 -> y1 = 0101 while y0 stays 1010.
REQ-031 Backpressure: with y0 full and y0_ready = 0, drive s = 0 with in_valid = 1 -> in_ready = 0 and y0 unchanged; switch to s = 1 -> in_ready = 1 and y1 is accepted.
REQ-032 Streaming: y0_ready = 1 constantly and words 1100 then 0011 sent back-to-back to channel 0 -> y0_valid stays high for 2 consecutive cycles, y0 shows 1100 then 0011, and cnt0 = 2.
REQ-033 Counter wrap: 256 transfers on channel 1 -> cnt1 = 0 and cnt0 is unchanged.
REQ-034 Reset mid-operation: both channels full, then rst = 1 for 1 cycle -> both valid flags are 0, both counters are 0, and the old data is never delivered.
